// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-stage access controller placed directly in front of DataMemory.
//   Takes one load/store request at a time over a valid/ready handshake, checks
//   alignment, extracts and sign/zero-extends load data from the addressed byte
//   lanes, and does a read-modify-write for stores narrower than a doubleword.
//
// Ports
//   clk, reset              single clock; synchronous active-high reset
//   req_valid/req_ready     request handshake (ready only while idle)
//   req_write               1 = store, 0 = load
//   req_size                00 byte, 01 half, 10 word, 11 dword
//   req_signed              load extension select (ignored for dword)
//   req_addr, req_wdata     byte address and right-justified store data
//   resp_valid/resp_ready   response handshake; response held until accepted
//   resp_rdata, resp_error  extended load data (0 for stores/errors), misalignment flag
//   memRead, memWrite       DataMemory strobes, never both high
//   address, writeData      DataMemory address (dword aligned) and write data
//   readData                DataMemory read data, valid in the second read cycle

module load_store_unit #(
    parameter int unsigned ADDR_W = 48,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic              memRead,
    output logic              memWrite,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] writeData,
    input  logic [DATA_W-1:0] readData
);

    typedef enum logic [2:0] {
        StIdle,
        StRdIssue,
        StRdWait,
        StWr,
        StResp
    } state_t;

    state_t            state;
    logic              isWrite;
    logic              isSigned;
    logic [1:0]        reqSize;
    logic [2:0]        laneSel;
    logic [DATA_W-1:0] storeData;

    logic              reqMisaligned;
    logic [DATA_W-1:0] sizeMask;
    logic [DATA_W-1:0] laneMask;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] extData;
    logic [DATA_W-1:0] mergedData;

    // Alignment of the incoming request: addr mod 2^size must be zero.
    always_comb begin
        case (req_size)
            2'd0:    reqMisaligned = 1'b0;
            2'd1:    reqMisaligned = req_addr[0];
            2'd2:    reqMisaligned = |req_addr[1:0];
            default: reqMisaligned = |req_addr[2:0];
        endcase
    end

    // Byte-lane handling for the latched request, little-endian.
    always_comb begin
        case (reqSize)
            2'd0:    sizeMask = {{(DATA_W-8){1'b0}}, 8'hFF};
            2'd1:    sizeMask = {{(DATA_W-16){1'b0}}, 16'hFFFF};
            2'd2:    sizeMask = {{(DATA_W-32){1'b0}}, 32'hFFFF_FFFF};
            default: sizeMask = '1;
        endcase
        laneMask   = sizeMask << {laneSel, 3'b000};
        shifted    = readData >> {laneSel, 3'b000};
        mergedData = (readData & ~laneMask) | ((storeData << {laneSel, 3'b000}) & laneMask);
        case (reqSize)
            2'd0:    extData = {{(DATA_W-8){isSigned & shifted[7]}}, shifted[7:0]};
            2'd1:    extData = {{(DATA_W-16){isSigned & shifted[15]}}, shifted[15:0]};
            2'd2:    extData = {{(DATA_W-32){isSigned & shifted[31]}}, shifted[31:0]};
            default: extData = shifted;
        endcase
    end

    assign req_ready = (state == StIdle);

    // Strobes are gated by reset so an abandoned access never reaches memory.
    assign memRead  = !reset && ((state == StRdIssue) || (state == StRdWait));
    assign memWrite = !reset && (state == StWr);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            isWrite    <= 1'b0;
            isSigned   <= 1'b0;
            reqSize    <= 2'd0;
            laneSel    <= 3'd0;
            storeData  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
            address    <= '0;
            writeData  <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (req_valid) begin
                        isWrite   <= req_write;
                        isSigned  <= req_signed;
                        reqSize   <= req_size;
                        laneSel   <= req_addr[2:0];
                        storeData <= req_wdata;
                        address   <= {req_addr[ADDR_W-1:3], 3'b000};
                        if (reqMisaligned) begin
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= '0;
                            state      <= StResp;
                        end else if (req_write && (req_size == 2'd3)) begin
                            // Full dword store needs no read; write data goes straight out.
                            writeData <= req_wdata;
                            state     <= StWr;
                        end else begin
                            state <= StRdIssue;
                        end
                    end
                end
                StRdIssue: state <= StRdWait;
                StRdWait: begin
                    if (isWrite) begin
                        writeData <= mergedData;
                        state     <= StWr;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_error <= 1'b0;
                        resp_rdata <= extData;
                        state      <= StResp;
                    end
                end
                StWr: begin
                    resp_valid <= 1'b1;
                    resp_error <= 1'b0;
                    resp_rdata <= '0;
                    state      <= StResp;
                end
                StResp: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [47:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_error;
    logic        memRead;
    logic        memWrite;
    logic [47:0] address;
    logic [63:0] writeData;
    logic [63:0] readData;

    int nVec  = 0;
    int nFail = 0;

    // DataMemory stand-in: 16 dwords at 0x00..0x7F, one-cycle registered read.
    logic [63:0] mem    [16];
    logic [63:0] refMem [16];
    logic [63:0] rdReg;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(48), .DATA_W(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .address    (address),
        .writeData  (writeData),
        .readData   (readData)
    );

    // Garbage unless a read was issued the previous cycle.
    always @(posedge clk) begin
        if (memRead) rdReg <= mem[address[6:3]];
        else         rdReg <= {$urandom, $urandom};
        if (memWrite) mem[address[6:3]] <= writeData;
    end
    assign readData = rdReg;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("rw_exclusive", {63'd0, memRead & memWrite}, 64'd0);
    end

    // One full transaction; expectations come from the byte-level reference memory.
    task automatic doReq(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [47:0] ad, input logic [63:0] wd, input int hold,
                         output logic [63:0] rd);
        int          bytes;
        int          lane;
        int          idx;
        logic        mis;
        int          expLat, expReads, expWrites;
        logic [63:0] expRd, expWd, raw;
        logic        expErr;
        int          cyc, reads, writes;
        logic        addrBad;
        logic [63:0] wdSeen, heldRd;

        bytes = 1 << sz;
        lane  = int'(ad[2:0]);
        idx   = int'(ad[6:3]);
        mis   = (ad % bytes) != 0;
        expRd = 64'd0;
        expWd = refMem[idx];
        expErr = 1'b0;
        if (mis) begin
            expLat = 1; expReads = 0; expWrites = 0; expErr = 1'b1;
        end else if (wr) begin
            for (int b = 0; b < bytes; b++) expWd[(lane + b) * 8 +: 8] = wd[b * 8 +: 8];
            expLat    = (sz == 2'd3) ? 2 : 4;
            expReads  = (sz == 2'd3) ? 0 : 2;
            expWrites = 1;
        end else begin
            raw = refMem[idx] >> (8 * lane);
            for (int b = 0; b < 8; b++)
                expRd[b * 8 +: 8] = (b < bytes) ? raw[b * 8 +: 8] :
                    ((sg && raw[bytes * 8 - 1]) ? 8'hFF : 8'h00);
            expLat = 3; expReads = 2; expWrites = 0;
        end

        chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = ad; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = $urandom; req_size = 2'($urandom);
        req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};

        cyc = 1; reads = 0; writes = 0; addrBad = 1'b0; wdSeen = 64'd0;
        forever begin
            if (memRead)  reads++;
            if (memWrite) begin writes++; wdSeen = writeData; end
            if ((memRead || memWrite) && address !== {ad[47:3], 3'b000}) addrBad = 1'b1;
            if (resp_valid || cyc >= 12) break;
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", 64'(cyc), 64'(expLat));
        chk("read_cycles", 64'(reads), 64'(expReads));
        chk("write_cycles", 64'(writes), 64'(expWrites));
        chk("mem_address", {63'd0, addrBad}, 64'd0);
        if (expWrites == 1) chk("write_data", wdSeen, expWd);
        chk("resp_rdata", resp_rdata, expRd);
        chk("resp_error", {63'd0, resp_error}, {63'd0, expErr});
        rd = resp_rdata;
        heldRd = resp_rdata;

        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", {63'd0, resp_valid}, 64'd1);
            chk("hold_rdata", resp_rdata, heldRd);
            chk("hold_ready", {63'd0, req_ready}, 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("resp_drop", {63'd0, resp_valid}, 64'd0);
        chk("ready_after", {63'd0, req_ready}, 64'd1);

        if (!mis && wr) refMem[idx] = expWd;
        chk("mem_contents", mem[idx], refMem[idx]);
    endtask

    initial begin
        logic [63:0] rd;
        logic        sawWrite;

        for (int i = 0; i < 16; i++) begin
            mem[i]    = {$urandom, $urandom};
            refMem[i] = mem[i];
        end
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_resp_error", {63'd0, resp_error}, 64'd0);
        chk("rst_address", {16'd0, address}, 64'd0);
        chk("rst_writeData", writeData, 64'd0);
        chk("rst_strobes", {62'd0, memRead, memWrite}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed walk-through of the documented scenarios.
        doReq(1'b1, 2'd3, 1'b0, 48'h40, 64'h1122334455667788, 0, rd);
        doReq(1'b0, 2'd0, 1'b1, 48'h47, 64'd0, 0, rd);
        chk("ld_byte_0x47", rd, 64'h11);
        doReq(1'b1, 2'd0, 1'b0, 48'h41, 64'h80, 0, rd);
        doReq(1'b0, 2'd0, 1'b1, 48'h41, 64'd0, 0, rd);
        chk("ld_byte_signed", rd, 64'hFFFFFFFFFFFFFF80);
        doReq(1'b0, 2'd0, 1'b0, 48'h41, 64'd0, 0, rd);
        chk("ld_byte_unsigned", rd, 64'h80);
        doReq(1'b1, 2'd3, 1'b0, 48'h40, 64'h1122334455667788, 0, rd);
        doReq(1'b1, 2'd1, 1'b0, 48'h44, 64'hBEEF, 0, rd);
        chk("half_merge", mem[8], 64'h1122BEEF55667788);
        doReq(1'b0, 2'd2, 1'b0, 48'h42, 64'd0, 0, rd);
        doReq(1'b0, 2'd3, 1'b0, 48'h40, 64'd0, 3, rd);
        chk("ld_dword_held", rd, 64'h1122BEEF55667788);

        // Reset during the RD_WAIT cycle of a sub-dword store.
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_signed = 1'b0;
        req_addr = 48'h22; req_wdata = 64'hA5A5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        sawWrite = memWrite;
        @(posedge clk); #1;
        sawWrite |= memWrite;
        reset = 1'b1;
        sawWrite |= memWrite;
        @(posedge clk); #1;
        chk("mid_rst_valid", {63'd0, resp_valid}, 64'd0);
        chk("mid_rst_rdata", resp_rdata, 64'd0);
        chk("mid_rst_address", {16'd0, address}, 64'd0);
        chk("mid_rst_writeData", writeData, 64'd0);
        chk("mid_rst_ready", {63'd0, req_ready}, 64'd1);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            sawWrite |= memWrite;
        end
        chk("mid_rst_no_write", {63'd0, sawWrite}, 64'd0);
        chk("mid_rst_mem", mem[4], refMem[4]);

        // Randomized traffic against the reference memory.
        for (int n = 0; n < 150; n++) begin
            doReq(1'($urandom), 2'($urandom), 1'($urandom), {41'd0, 7'($urandom)},
                  {$urandom, $urandom}, int'($urandom_range(0, 2)), rd);
        end
        for (int i = 0; i < 16; i++) chk("final_mem", mem[i], refMem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
